seg_scan_drv: RTL and testbench
===============================

# seg_scan_drv

Time-multiplexed driver for the two 4-digit seven-segment groups of the washer panel. It takes BCD digit words and per-digit masks from the controller FSM and produces scanned segment/enable patterns for `led_l/ena_l` and `led_r/ena_r`, so phase modules no longer hand-build segment bytes. Load requests are double-buffered and applied only on a frame boundary, so a display frame never shows half-old, half-new values.

## Interface
- `DIGIT_CYCLES`, default 100000: clk cycles per digit slot (1 ms at 100 MHz). Minimum 2.
- `BLINK_FRAMES`, default 125: frames per blink half-period (0.5 s at default).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `load` in 1: one-cycle request to capture all data inputs into the staging registers.
- `val_l` in 16: left group, 4 BCD digits; [15:12] is the leftmost digit.
- `val_r` in 16: right group, same layout.
- `blank` in 8: per-digit force-off; [7:4] = left group, [3:0] = right group; MSB of each nibble = leftmost digit.
- `dp` in 8: per-digit decimal point, same bit mapping as `blank`.
- `blink` in 8: per-digit blink enable, same mapping.
- `lz_en` in 1: leading-zero suppression for both groups.
- `pending` out 1: staged data is waiting for a frame boundary.
- `frame` out 1: one-cycle pulse at each frame boundary.
- `led_l`, `led_r` out 8: segments {a,b,c,d,e,f,g,dp}, active-high.
- `ena_l`, `ena_r` out 4: digit enables, active-high, one-hot or zero; bit 3 = leftmost digit.

## Operation
- Slot counter `cnt` runs 0..DIGIT_CYCLES-1. Digit index `idx` runs 0..3 and advances when `cnt` wraps. Both groups scan in lockstep on the same `idx`.
- Boundary = `cnt==DIGIT_CYCLES-1 && idx==3`. On that cycle `frame`=1, and if `pending`=1 then display regs <= staging regs and `pending` clears.
- Load handling:
  - `load`=1 sets staging <= inputs and `pending`=1.
  - If several loads arrive before a boundary, the last one wins.
  - Load coincident with a boundary: display takes the previous staging contents, staging takes the new inputs, `pending` stays 1.
- Digit decode:
  - 0..9 map to standard glyphs.
  - Nibbles A..F show a dash (segment g only).
  - `dp` bit ORs into bit 0.
- A digit is dark (led=0 and ena bit=0) when any of these holds:
  - its `blank` bit is set;
  - it is a leading zero (`lz_en`=1, digit value 0, and every digit to its left in the group is 0 or suppressed; the rightmost digit is never suppressed);
  - its blink bit is set and blink phase = 1.
- Dead time: during `cnt==0` of every slot, ena = 0 on both groups (ghosting guard). led still shows the new digit.
- Blink phase toggles after every BLINK_FRAMES boundaries. The frame counter wraps at BLINK_FRAMES-1.

## Timing
- Outputs are registered and lag `cnt/idx` by 1 cycle.
- Frame length is 4*DIGIT_CYCLES cycles.
- Worst-case load-to-visible latency is one frame plus 1 cycle.
- Reset values:
  - `cnt`, `idx`, blink counter and phase: 0.
  - Display and staging: `val`=0, `blank`=8'hFF, `dp`=0, `blink`=0.
  - `pending`=0, `frame`=0, `led_l`=`led_r`=0, `ena_l`=`ena_r`=0.
- Reset mid-frame: the staged load is discarded and the panel goes dark until the first boundary after the next `load`.
- `lz_en` is captured with `load` like the other data inputs.

## Configuration
- `SEG_BLINK_EN` defined: the blink counter and phase are built, and `blink` behaves as described.
- `SEG_BLINK_EN` undefined: the `blink` port remains but is ignored, no blink counter is synthesized, and phase is constant 0.

## Structure
- Shared package `seg_pkg`:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - digit-index type (2 bits);
  - bit-mapping localparams for the group nibbles.
- Sub-module `seg_decode`: combinational, 4-bit BCD + dp -> 8-bit segment pattern, instantiated once per group.
- Scan, staging and blink logic live in `seg_scan_drv`.

## Test plan
Bench uses DIGIT_CYCLES=4 and BLINK_FRAMES=2.
- Reset release with no load -> all outputs 0 indefinitely; `frame` pulses every 16 cycles.
- Load `val_l`=16'h1234, `blank`=0 mid-frame -> `pending`=1 until next `frame`. Following frame:
  - `ena_l` sequences 0001,0010,0100,1000, each preceded by one dead cycle;
  - `led_l` = SEG_4, SEG_3, SEG_2, SEG_1.
- Load `val_r`=16'h0050 with `lz_en`=1 -> right digits 3 dark, 2 shows SEG_0? No: digit 3 dark, digits 2..0 = 0,5,0 -> digit 2 dark as a leading zero, digit 1 = SEG_5, digit 0 = SEG_0 (never suppressed).
- Two loads (16'h1111 then 16'h2222) before one boundary -> only 16'h2222 is ever displayed. A load on the exact boundary cycle appears one frame later with `pending` held.
- `val_l`=16'hA000 -> leftmost digit = SEG_DASH. `dp`=8'h10 -> left digit 0 led bit 0 = 1.
- With `SEG_BLINK_EN` and `blink`=8'h01 -> right digit 0 dark for 2 frames, lit for 2 frames, repeating. Without the macro -> always lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: glyphs, digit index type,
// group bit mapping and the display-state record.
package seg_pkg;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef logic [1:0] digit_idx_t;

  // Per-digit masks: left group in the upper nibble, right group in the lower one.
  localparam int unsigned GRP_W      = 4;
  localparam int unsigned GRP_L_LSB  = 4;
  localparam int unsigned GRP_R_LSB  = 0;

  typedef struct packed {
    logic [15:0] val_l;
    logic [15:0] val_r;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [7:0]  blink;
    logic        lz_en;
  } disp_t;

  localparam disp_t DISP_RESET = '{
    val_l: 16'h0000,
    val_r: 16'h0000,
    blank: 8'hFF,
    dp:    8'h00,
    blink: 8'h00,
    lz_en: 1'b0
  };

  // Bit i set when digit i is a suppressed leading zero; digit 0 always shows.
  function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic en);
    logic [3:0] m;
    m[3] = en && (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// BCD nibble plus decimal point to seven-segment pattern; A..F render as a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

  assign seg = glyph | {7'b0, dp};

endmodule

// File: rtl/seg_scan_drv.sv
// Double-buffered, time-multiplexed driver for two 4-digit seven-segment groups.
// Define SEG_BLINK_EN to build the per-digit blink counter; otherwise blink is ignored.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] val_l,
  input  logic [15:0] val_r,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp,
  input  logic [7:0]  blink,
  input  logic        lz_en,
  output logic        pending,
  output logic        frame,
  output logic [7:0]  led_l,
  output logic [7:0]  led_r,
  output logic [3:0]  ena_l,
  output logic [3:0]  ena_r
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  digit_idx_t       idx_q;
  disp_t            stage_d, stage_q, disp_q;
  logic             pending_q;
  logic             boundary;

  assign boundary = (cnt_q == CNT_MAX) && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    stage_d       = DISP_RESET;
    stage_d.val_l = val_l;
    stage_d.val_r = val_r;
    stage_d.blank = blank;
    stage_d.dp    = dp;
    stage_d.blink = blink;
    stage_d.lz_en = lz_en;
  end

  // Display takes the old staging contents even when a load lands on the boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q   <= DISP_RESET;
      disp_q    <= DISP_RESET;
      pending_q <= 1'b0;
    end else begin
      if (boundary && pending_q) begin
        disp_q <= stage_q;
      end
      if (load) begin
        stage_q   <= stage_d;
        pending_q <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  logic [3:0] blk_l, blk_r;

`ifdef SEG_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] bcnt_q;
  logic             phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (boundary) begin
      if (bcnt_q == BLK_MAX) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  assign blk_l = disp_q.blink[GRP_L_LSB +: GRP_W] & {4{phase_q}};
  assign blk_r = disp_q.blink[GRP_R_LSB +: GRP_W] & {4{phase_q}};
`else
  logic unused_blink;
  assign unused_blink = ^disp_q.blink;
  assign blk_l        = 4'b0000;
  assign blk_r        = 4'b0000;
`endif

  logic [3:0] nib_l, nib_r, dp_l, dp_r, bl_l, bl_r, lzm_l, lzm_r;
  logic [7:0] seg_l, seg_r;
  logic       dark_l, dark_r;
  logic [3:0] sel;

  assign nib_l = disp_q.val_l[{idx_q, 2'b00} +: 4];
  assign nib_r = disp_q.val_r[{idx_q, 2'b00} +: 4];
  assign dp_l  = disp_q.dp[GRP_L_LSB +: GRP_W];
  assign dp_r  = disp_q.dp[GRP_R_LSB +: GRP_W];
  assign bl_l  = disp_q.blank[GRP_L_LSB +: GRP_W];
  assign bl_r  = disp_q.blank[GRP_R_LSB +: GRP_W];
  assign lzm_l = lz_mask(disp_q.val_l, disp_q.lz_en);
  assign lzm_r = lz_mask(disp_q.val_r, disp_q.lz_en);

  seg_decode u_dec_l (
    .bcd (nib_l),
    .dp  (dp_l[idx_q]),
    .seg (seg_l)
  );

  seg_decode u_dec_r (
    .bcd (nib_r),
    .dp  (dp_r[idx_q]),
    .seg (seg_r)
  );

  assign dark_l = bl_l[idx_q] | lzm_l[idx_q] | blk_l[idx_q];
  assign dark_r = bl_r[idx_q] | lzm_r[idx_q] | blk_r[idx_q];
  assign sel    = 4'b0001 << idx_q;

  logic [7:0] led_l_q, led_r_q;
  logic [3:0] ena_l_q, ena_r_q;

  // First cycle of each slot keeps enables low so the old digit cannot ghost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_l_q <= SEG_OFF;
      led_r_q <= SEG_OFF;
      ena_l_q <= 4'b0000;
      ena_r_q <= 4'b0000;
    end else begin
      led_l_q <= dark_l ? SEG_OFF : seg_l;
      led_r_q <= dark_r ? SEG_OFF : seg_r;
      ena_l_q <= (dark_l || cnt_q == '0) ? 4'b0000 : sel;
      ena_r_q <= (dark_r || cnt_q == '0) ? 4'b0000 : sel;
    end
  end

  assign pending = pending_q;
  assign frame   = boundary;
  assign led_l   = led_l_q;
  assign led_r   = led_r_q;
  assign ena_l   = ena_l_q;
  assign ena_r   = ena_r_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Randomised bench for seg_scan_drv against a frame-level behavioural model.
module tb_seg_scan_drv;

  localparam int unsigned DC    = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] val_l = '0, val_r = '0;
  logic [7:0]  blank = '0, dp = '0, blink = '0;
  logic        lz_en = 1'b0;
  logic        pending, frame;
  logic [7:0]  led_l, led_r;
  logic [3:0]  ena_l, ena_r;

  always #5 clk = ~clk;

  seg_scan_drv #(
    .DIGIT_CYCLES (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .val_l   (val_l),
    .val_r   (val_r),
    .blank   (blank),
    .dp      (dp),
    .blink   (blink),
    .lz_en   (lz_en),
    .pending (pending),
    .frame   (frame),
    .led_l   (led_l),
    .led_r   (led_r),
    .ena_l   (ena_l),
    .ena_r   (ena_r)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] vl, vr;
    logic [7:0]  bl, dp, bk;
    logic        lz;
  } cfg_t;

  localparam logic [7:0] GLYPH [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  function automatic cfg_t cfg_reset();
    cfg_t c;
    c.vl = '0; c.vr = '0; c.bl = 8'hFF; c.dp = '0; c.bk = '0; c.lz = 1'b0;
    return c;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] n);
    if (n > 4'd9) return 8'h02;
    return GLYPH[int'(n)];
  endfunction

  function automatic bit lead_zero(input logic [15:0] v, input int i, input logic lz);
    if (!lz || i == 0) return 1'b0;
    for (int j = i; j < 4; j++) if (v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit phase_of(input int n);
`ifdef SEG_BLINK_EN
    return ((n / BF) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void expect_grp(input logic [15:0] v, input logic [3:0] bln,
                                     input logic [3:0] dpn, input logic [3:0] bkn,
                                     input logic lz, input int i, input int slot, input bit ph,
                                     output logic [7:0] led, output logic [3:0] ena);
    bit dark;
    dark = bln[i] || lead_zero(v, i, lz) || (bkn[i] && ph);
    led  = dark ? 8'h00 : (glyph(v[4*i +: 4]) | {7'b0, dpn[i]});
    ena  = (dark || slot == 0) ? 4'b0000 : 4'(1 << i);
  endfunction

  cfg_t m_disp, m_stage, p_disp;
  bit   m_pend, p_valid, p_phase;
  int   nb, k, p_k;

  // k counts cycles since reset release; outputs in cycle k reflect cycle k-1.
  always @(negedge clk) begin
    logic [7:0] el, er;
    logic [3:0] eel, eer;
    if (!rst) begin
      m_disp = cfg_reset(); m_stage = cfg_reset(); p_disp = cfg_reset();
      m_pend = 0; nb = 0; k = 0; p_valid = 0; p_phase = 0; p_k = 0;
      chk("rst_led_l", led_l, 0);  chk("rst_led_r", led_r, 0);
      chk("rst_ena_l", ena_l, 0);  chk("rst_ena_r", ena_r, 0);
      chk("rst_pending", pending, 0); chk("rst_frame", frame, 0);
    end else begin
      if (p_valid) begin
        expect_grp(p_disp.vl, p_disp.bl[7:4], p_disp.dp[7:4], p_disp.bk[7:4], p_disp.lz,
                   (p_k / DC) % 4, p_k % DC, p_phase, el, eel);
        expect_grp(p_disp.vr, p_disp.bl[3:0], p_disp.dp[3:0], p_disp.bk[3:0], p_disp.lz,
                   (p_k / DC) % 4, p_k % DC, p_phase, er, eer);
      end else begin
        el = 0; er = 0; eel = 0; eer = 0;
      end
      chk("led_l", led_l, el);
      chk("led_r", led_r, er);
      chk("ena_l", ena_l, eel);
      chk("ena_r", ena_r, eer);
      chk("frame", frame, (k % FRAME) == FRAME - 1);
      chk("pending", pending, m_pend);
      p_disp = m_disp; p_phase = phase_of(nb); p_k = k; p_valid = 1;
      if ((k % FRAME) == FRAME - 1) begin
        if (m_pend) begin
          m_disp = m_stage;
          m_pend = 0;
        end
        nb++;
      end
      if (load) begin
        m_stage = '{vl: val_l, vr: val_r, bl: blank, dp: dp, bk: blink, lz: lz_en};
        m_pend  = 1;
      end
      k++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [15:0] vl, input logic [15:0] vr, input logic [7:0] bl,
                         input logic [7:0] d, input logic [7:0] bk, input logic lz);
    @(posedge clk); #1;
    val_l = vl; val_r = vr; blank = bl; dp = d; blink = bk; lz_en = lz; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 3 * FRAME);
    if (frame !== 1'b1) chk("frame_timeout", 0, 1);
  endtask

  // Literal check of the complete frame following the next boundary.
  task automatic watch_frame(input string name, input logic [31:0] ll, input logic [31:0] lr,
                             input logic [3:0] lit_l, input logic [3:0] lit_r);
    wait_frame();
    @(negedge clk);
    for (int j = 0; j < int'(FRAME); j++) begin
      int d, s;
      @(negedge clk);
      d = j / DC; s = j % DC;
      chk({name, "_led_l"}, led_l, ll[8*d +: 8]);
      chk({name, "_led_r"}, led_r, lr[8*d +: 8]);
      chk({name, "_ena_l"}, ena_l, (s == 0 || !lit_l[d]) ? 0 : (1 << d));
      chk({name, "_ena_r"}, ena_r, (s == 0 || !lit_r[d]) ? 0 : (1 << d));
    end
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    int nf;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset: dark panel, frame every 16 cycles.
    nf = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (frame) nf++;
    end
    chk("idle_frame_count", nf, 3);
    chk("idle_led_l", led_l, 0);

    do_load(16'h1234, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("pending_after_load", pending, 1);
    watch_frame("v1234", {8'h60, 8'hDA, 8'hF2, 8'h66}, {4{8'hFC}}, 4'hF, 4'hF);
    chk("pending_cleared", pending, 0);

    do_load(16'h0000, 16'h0050, 8'h00, 8'h00, 8'h00, 1'b1);
    watch_frame("lz", {8'h00, 8'h00, 8'h00, 8'hFC}, {8'h00, 8'h00, 8'hB6, 8'hFC},
                4'b0001, 4'b0011);

    do_load(16'h1111, 16'h1111, 8'h00, 8'h00, 8'h00, 1'b0);
    do_load(16'h2222, 16'h2222, 8'h00, 8'h00, 8'h00, 1'b0);
    watch_frame("last_wins", {4{8'hDA}}, {4{8'hDA}}, 4'hF, 4'hF);

    // Load landing exactly on a boundary while an earlier load is still pending.
    wait_frame();
    do_load(16'h5555, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    val_l = 16'h6666; val_r = 16'h6666; load = 1'b1;
    chk("on_boundary_frame", frame, 1);
    @(posedge clk); #1;
    load = 1'b0;
    chk("pending_held", pending, 1);
    watch_frame("boundary", {4{8'hBE}}, {4{8'hBE}}, 4'hF, 4'hF);

    do_load(16'hA000, 16'h0000, 8'h00, 8'h10, 8'h00, 1'b0);
    watch_frame("dash_dp", {8'h02, 8'hFC, 8'hFC, 8'hFD}, {4{8'hFC}}, 4'hF, 4'hF);

    // Blink on right digit 0; the model carries the phase over several frames.
    do_load(16'h1234, 16'h1234, 8'h00, 8'h00, 8'h01, 1'b0);
    repeat (6 * FRAME) @(posedge clk);

    // Reset mid-frame discards the pending load and darkens the panel.
    do_load(16'h9999, 16'h9999, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("post_rst_led_l", led_l, 0);
    chk("post_rst_ena_r", ena_r, 0);

    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) == 0) begin
        val_l = rand_val(); val_r = rand_val();
        blank = 8'($urandom) & 8'($urandom);
        dp    = 8'($urandom);
        blink = 8'($urandom) & 8'($urandom);
        lz_en = 1'($urandom);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    repeat (2 * FRAME) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
